// File: rtl/register_file_mp.sv
// Multi-read-port register file with x0 hardwired to zero, optional write-to-read
// forwarding, and a background clear sweep that zeros one register per cycle.
module register_file_mp #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 32,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Reg_WRITE,
  input  logic [$clog2(DEPTH)-1:0]  WRITE_Addr,
  input  logic [XLEN-1:0]           WRITE_Data,
  input  logic [NREAD*$clog2(DEPTH)-1:0] READ_Addr,
  output logic [NREAD*XLEN-1:0]     READ_Data,
  input  logic                      clear_req,
  output logic                      clear_busy,
  output logic                      write_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state, state_next;
  logic [AW-1:0]   cnt, cnt_next;
  logic [XLEN-1:0] regs [DEPTH];
  logic            wr_req;
  logic            wr_en;
  logic            drop_next;

  // A write to x0 is never a real request, so it can neither land nor be dropped.
  assign wr_req    = Reg_WRITE && (WRITE_Addr != '0);
  assign wr_en     = wr_req && (state == IDLE);
  assign drop_next = wr_req && (state == CLEAR);

  assign clear_busy = (state == CLEAR);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_next = CLEAR;
          cnt_next   = AW'(1);
        end
      end
      CLEAR: begin
        // Counter wraps to zero naturally after the last index.
        cnt_next = cnt + 1'b1;
        if (cnt == LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      write_drop <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      write_drop <= drop_next;
    end
  end

  // Sweep and normal writes are mutually exclusive because writes only land in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (wr_en) regs[WRITE_Addr] <= WRITE_Data;
      if (state == CLEAR) regs[cnt] <= '0;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = READ_Addr[k*AW +: AW];
    assign READ_Data[k*XLEN +: XLEN] =
      (ra == '0)                                  ? '0 :
      ((BYPASS != 0) && wr_en && (ra == WRITE_Addr)) ? WRITE_Data :
                                                      regs[ra];
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Randomized self-checking bench for register_file_mp: a forwarding and a
// non-forwarding instance share stimulus and are compared with an array model.
module tb_register_file_mp;

  localparam int XLEN = 32;
  localparam int DEPTH = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  logic                 clk;
  logic                 reset;
  logic                 we;
  logic [AW-1:0]        wa;
  logic [XLEN-1:0]      wd;
  logic [NR*AW-1:0]     ra;
  logic [NR*XLEN-1:0]   rd0, rd1;
  logic                 clear_req;
  logic                 busy0, busy1, drop0, drop1;

  int n_checks;
  int n_fail;

  // Reference state
  logic [XLEN-1:0] mem [DEPTH];
  int              m_left;   // sweep cycles still to run; 0 means idle
  logic            m_drop;

  register_file_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NREAD(NR), .BYPASS(1)) dut_byp (
    .clk(clk), .reset(reset), .Reg_WRITE(we), .WRITE_Addr(wa), .WRITE_Data(wd),
    .READ_Addr(ra), .READ_Data(rd0), .clear_req(clear_req),
    .clear_busy(busy0), .write_drop(drop0));

  register_file_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NREAD(NR), .BYPASS(0)) dut_nobyp (
    .clk(clk), .reset(reset), .Reg_WRITE(we), .WRITE_Addr(wa), .WRITE_Data(wd),
    .READ_Addr(ra), .READ_Data(rd1), .clear_req(clear_req),
    .clear_busy(busy1), .write_drop(drop1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    m_left = 0;
    m_drop = 1'b0;
  endfunction

  // Advance the model by one rising edge using the inputs currently driven.
  function automatic void model_step();
    if (m_left == 0) begin
      m_drop = 1'b0;
      if (we && wa != 0) mem[wa] = wd;
      if (clear_req) m_left = DEPTH - 1;
    end else begin
      m_drop = we && (wa != 0);
      mem[DEPTH - m_left] = '0;
      m_left = m_left - 1;
    end
  endfunction

  function automatic logic [NR*XLEN-1:0] exp_rd(input bit byp);
    logic [NR*XLEN-1:0] r;
    logic [AW-1:0] a;
    logic [XLEN-1:0] v;
    r = '0;
    for (int k = 0; k < NR; k++) begin
      a = ra[k*AW +: AW];
      if (a == 0) v = '0;
      else if (byp && m_left == 0 && we && wa != 0 && wa == a) v = wd;
      else v = mem[a];
      r[k*XLEN +: XLEN] = v;
    end
    return r;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; we = 0; wa = 0; wd = 0; ra = 0; clear_req = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    ra = $urandom;
    #1;
    n_checks++;
    if (busy0 !== 1'b0 || drop0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl busy=%b drop=%b expected 0 0", busy0, drop0);
    end
    n_checks++;
    if (rd0 !== '0 || rd1 !== '0) begin
      n_fail++; $display("FAIL reset_reads got %h / %h expected 0", rd0, rd1);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    we = 1; wa = 5; wd = 32'hDEADBEEF;
    tick();
    we = 0; ra = {5'd0, 5'd0, 5'd0, 5'd5};
    #1;
    n_checks++;
    if (rd0[31:0] !== 32'hDEADBEEF || rd0[63:32] !== 32'h0) begin
      n_fail++; $display("FAIL basic_read got p0=%h p1=%h expected deadbeef 0", rd0[31:0], rd0[63:32]);
    end
    n_checks++;
    if (rd1[31:0] !== 32'hDEADBEEF || rd1[63:32] !== 32'h0) begin
      n_fail++; $display("FAIL basic_read_nobyp got p0=%h p1=%h expected deadbeef 0", rd1[31:0], rd1[63:32]);
    end
  endtask

  task automatic test_x0();
    we = 1; wa = 0; wd = 32'd10; ra = '0;
    #1;
    n_checks++;
    if (rd0[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL x0_same_cycle got %h expected 0", rd0[31:0]);
    end
    tick();
    we = 0;
    #1;
    n_checks++;
    if (rd0[31:0] !== 32'h0 || drop0 !== 1'b0) begin
      n_fail++; $display("FAIL x0_after got %h drop=%b expected 0 0", rd0[31:0], drop0);
    end
  endtask

  task automatic test_bypass();
    we = 1; wa = 7; wd = 32'h55; ra = {5'd0, 5'd0, 5'd7, 5'd0};
    #1;
    n_checks++;
    if (rd0[63:32] !== 32'h55) begin
      n_fail++; $display("FAIL bypass_on got %h expected 55", rd0[63:32]);
    end
    n_checks++;
    if (rd1[63:32] !== 32'h0) begin
      n_fail++; $display("FAIL bypass_off got %h expected 0", rd1[63:32]);
    end
    tick();
    we = 0;
    #1;
    n_checks++;
    if (rd0[63:32] !== 32'h55 || rd1[63:32] !== 32'h55) begin
      n_fail++; $display("FAIL bypass_stored got %h / %h expected 55", rd0[63:32], rd1[63:32]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      we = $urandom_range(0, 1); wa = $urandom; wd = $urandom; ra = $urandom;
      if (c % 7 == 0) ra[AW-1:0] = wa;
      clear_req = 0;
      #1;
      n_checks++;
      if (rd0 !== exp_rd(1'b1)) begin
        n_fail++; $display("FAIL rand_byp cyc=%0d got %h expected %h", c, rd0, exp_rd(1'b1));
      end
      n_checks++;
      if (rd1 !== exp_rd(1'b0)) begin
        n_fail++; $display("FAIL rand_nobyp cyc=%0d got %h expected %h", c, rd1, exp_rd(1'b0));
      end
      n_checks++;
      if (drop0 !== m_drop || busy0 !== 1'b0) begin
        n_fail++; $display("FAIL rand_ctrl cyc=%0d drop=%b busy=%b expected %b 0", c, drop0, busy0, m_drop);
      end
      tick();
    end
    we = 0;
  endtask

  task automatic test_clear();
    int busy_cnt;
    int drop_cnt;
    busy_cnt = 0; drop_cnt = 0;
    for (int i = 1; i < DEPTH; i++) begin
      we = 1; wa = i[AW-1:0]; wd = i;
      tick();
    end
    // A write in the request cycle still lands before the sweep begins.
    we = 1; wa = 20; wd = 32'h1234; clear_req = 1; ra = {4{5'd20}};
    #1;
    n_checks++;
    if (busy0 !== 1'b0) begin
      n_fail++; $display("FAIL clear_busy_comb got %b expected 0", busy0);
    end
    tick();
    we = 0; clear_req = 0;
    for (int c = 0; c < 40; c++) begin
      ra = $urandom;
      we = (c == 9); wa = 3; wd = 32'hFFFF;
      clear_req = (c == 14);
      if (c == 9) ra[2*AW +: AW] = 3;
      #1;
      if (busy0 === 1'b1) busy_cnt++;
      if (drop0 === 1'b1) drop_cnt++;
      n_checks++;
      if (busy0 !== (m_left != 0) || drop0 !== m_drop) begin
        n_fail++; $display("FAIL clear_ctrl cyc=%0d busy=%b drop=%b expected %b %b", c, busy0, drop0, m_left != 0, m_drop);
      end
      n_checks++;
      if (rd0 !== exp_rd(1'b1) || rd1 !== exp_rd(1'b0)) begin
        n_fail++; $display("FAIL clear_reads cyc=%0d got %h expected %h", c, rd0, exp_rd(1'b1));
      end
      tick();
    end
    we = 0; clear_req = 0;
    n_checks++;
    if (busy_cnt != DEPTH - 1) begin
      n_fail++; $display("FAIL clear_length got %0d cycles expected %0d", busy_cnt, DEPTH - 1);
    end
    n_checks++;
    if (drop_cnt != 1) begin
      n_fail++; $display("FAIL clear_drop_pulses got %0d expected 1", drop_cnt);
    end
    for (int g = 0; g < DEPTH / NR; g++) begin
      for (int k = 0; k < NR; k++) ra[k*AW +: AW] = AW'(g*NR + k);
      #1;
      n_checks++;
      if (rd0 !== '0) begin
        n_fail++; $display("FAIL clear_after group=%0d got %h expected 0", g, rd0);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [XLEN-1:0] v;
    for (int i = 1; i < DEPTH; i++) begin
      we = 1; wa = i[AW-1:0]; wd = $urandom | 1;
      tick();
    end
    we = 0; clear_req = 1;
    tick();
    clear_req = 0;
    repeat (10) tick();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (busy0 !== 1'b0 || drop0 !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_ctrl busy=%b drop=%b expected 0 0", busy0, drop0);
    end
    for (int g = 0; g < DEPTH / NR; g++) begin
      for (int k = 0; k < NR; k++) ra[k*AW +: AW] = AW'(g*NR + k);
      #1;
      n_checks++;
      if (rd0 !== '0 || rd1 !== '0) begin
        n_fail++; $display("FAIL async_reset_reads group=%0d got %h expected 0", g, rd0);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    v = $urandom;
    we = 1; wa = 9; wd = v; ra = {4{5'd9}};
    tick();
    we = 0;
    #1;
    n_checks++;
    if (rd0[31:0] !== v || rd0 !== exp_rd(1'b1) || busy0 !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_write got %h busy=%b expected %h", rd0[31:0], busy0, v);
    end
  endtask

  task automatic test_multiport();
    we = 1; wa = 12; wd = 32'hA5A5A5A5;
    tick();
    we = 0; ra = {4{5'd12}};
    #1;
    for (int k = 0; k < NR; k++) begin
      n_checks++;
      if (rd0[k*XLEN +: XLEN] !== 32'hA5A5A5A5 || rd1[k*XLEN +: XLEN] !== 32'hA5A5A5A5) begin
        n_fail++; $display("FAIL multiport port=%0d got %h / %h expected a5a5a5a5", k,
                           rd0[k*XLEN +: XLEN], rd1[k*XLEN +: XLEN]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_x0();
    test_bypass();
    test_random();
    test_clear();
    test_multiport();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
